issue_scoreboard: RTL
=====================

# issue_scoreboard

Single-issue hazard controller between decode and the execution units of MicroGT-01. Accepts one `instruction_t` per cycle into a one-entry holding register, decodes its integer/FP register usage, and blocks issue on RAW/WAW hazards against in-flight results. Routes each instruction to ALU, MULDIV, FPU or LSU with a valid/ready handshake and serialises FENCE/CSR instructions. Tracks pending destinations in two 32-bit scoreboards (integer, FP) cleared by writeback.

## Interface
- `WB_BYPASS`, default 1: a writeback clear in cycle N may release a blocked issue in the same cycle N (0: the release happens in N+1).
- `clk_i`  in  1  clock, all state on rising edge
- `rst_i`  in  1  asynchronous, active-high reset
- `flush_i`  in  1  synchronous; empties holding register, clears both scoreboards
- `iw_i`  in  32  `instruction_t` from decode
- `iw_valid_i`  in  1  `iw_i` valid
- `iw_ready_o`  out  1  holding register can accept
- `issue_valid_o`  out  1  held instruction is hazard-free and may issue
- `issue_unit_o`  out  2  `exec_unit_e`: ALU=0, MULDIV=1, FPU=2, LSU=3
- `issue_iw_o`  out  32  held instruction word
- `unit_ready_i`  in  4  per-unit ready, indexed by `exec_unit_e`
- `int_wb_valid_i` / `int_wb_rd_i`  in  1 / 5  integer writeback clears `int_pend[rd]`
- `fp_wb_valid_i` / `fp_wb_rd_i`  in  1 / 5  FP writeback clears `fp_pend[rd]`
- `illegal_o`  out  1  one-cycle pulse, unknown opcode dropped

## Operation
- Decode by opcode (sources / dest / unit):
  - LUI, AUIPC, JAL: none / int / ALU.
  - JALR, ALU_I: int rs1 / int / ALU. LOAD: int rs1 / int / LSU.
  - BRANCH: int rs1, rs2 / none / ALU. STORE: int rs1, rs2 / none / LSU.
  - REG_OP: int rs1, rs2 / int / MULDIV if funct7=0000001, else ALU.
  - FLOAD: int rs1 / fp / LSU. FSTORE: int rs1, fp rs2 / none / LSU.
  - FMADD, FMSUB, FNMSUB, FNMADD: fp rs1, rs2, rs3 / fp / FPU.
  - F_OPS by funct7:
    - FCVTW, FMV_CLS: fp rs1 / int.
    - FCMP: fp rs1, rs2 / int.
    - FCVTS, FMVWX: int rs1 / fp.
    - FSQRT: fp rs1 / fp.
    - Otherwise: fp rs1, rs2 / fp.
    - Unit is always FPU.
  - FENCE_O: none / none / ALU, serialising. ECSR: int rs1 / int / ALU, serialising.
  - Any other opcode: `illegal_o` pulses in the cycle after acceptance; the instruction is dropped and never issued.
- Integer X0 is never marked pending and never causes a hazard. FP F0 is an ordinary register.
- Hazard: any used source is pending (RAW), or the destination is pending (WAW).
- `issue_valid_o` = held & no hazard & (not serialising or both scoreboards all-zero).
  - It does not depend on `unit_ready_i`.
  - Once asserted it holds until fire, because pending bits are only set by issue.
- Fire = `issue_valid_o` & `unit_ready_i[issue_unit_o]`. On fire, the destination pending bit is set (X0 excluded).
- Set and writeback clear of the same bit in the same cycle: set wins.
- FSM:
  - EMPTY: accept when `iw_valid_i`, go to HELD.
  - HELD: on fire with a new accept, stay in HELD; on fire with no accept, go to EMPTY.
  - DRAIN is HELD with a serialising instruction waiting for both scoreboards to reach all-zero. It exits to EMPTY or HELD on fire.
- `iw_ready_o` = !flush_i & (EMPTY or fire this cycle).

## Timing
- Reset and flush values: both scoreboards 0, state EMPTY, `issue_valid_o`=0, `illegal_o`=0, `iw_ready_o`=1 (0 during a flush cycle).
- Flush has priority over accept, fire and writeback. An instruction presented during a flush cycle is not accepted.
- Latency: accepted at edge N, `issue_valid_o` can first be high in cycle N+1. Throughput is 1 instruction/cycle with no hazards.
- With `WB_BYPASS`=1, the writeback clear feeds the hazard check combinationally. With 0, only registered pending bits are checked.
- Asynchronous reset asserted mid-handshake discards the held instruction and all pending state immediately.

## Structure
- Shared package `INSTRUCTION_TYPE` gains:
  - `exec_unit_e` enum.
  - `reg_class_e` enum (NONE/INT/FP).
  - `iw_usage_s` struct: class per rs1, rs2, rs3, rd; unit; serialise; illegal.
- Sub-module `issue_decoder`: purely combinational `instruction_t` → `iw_usage_s`.
- Scoreboards, FSM and handshake stay in `issue_scoreboard`.

## Test plan
- ADDI x5,x0,1 then ADD x6,x5,x5; no writeback → second instruction held with `issue_valid_o`=0; `int_wb_valid_i`/rd=5 → issues the same cycle (`WB_BYPASS`=1), next cycle when 0.
- MUL x7,x1,x2 with `unit_ready_i`=0000 → `issue_valid_o`=1, `issue_unit_o`=1 stays stable; ready=0010 → fires, `int_pend[7]`=1.
- FMADD f3,f1,f2,f4 with `fp_pend[4]`=1 → blocked; FLOAD f4 writeback clears it → issues to FPU=2.
- CSRRW with `fp_pend[9]`=1 → DRAIN, no issue; fp writeback rd=9 → issues to ALU.
- Opcode 7'b1111111 → `illegal_o`=1 for one cycle, no issue, `iw_ready_o`=1 afterwards.
- `flush_i` while holding with `int_pend`=0x0000_0F00 → next cycle scoreboards 0, EMPTY; ADDI x0 issues and sets no pending bit.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared instruction types for the issue stage: raw instruction layout, opcode map,
// execution-unit and register-class enums, and the decoded usage record.
package issue_scoreboard_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  typedef enum logic [1:0] {
    UNIT_ALU    = 2'd0,
    UNIT_MULDIV = 2'd1,
    UNIT_FPU    = 2'd2,
    UNIT_LSU    = 2'd3
  } exec_unit_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_INT  = 2'd1,
    CLS_FP   = 2'd2
  } reg_class_e;

  typedef struct packed {
    reg_class_e rs1_cls;
    reg_class_e rs2_cls;
    reg_class_e rs3_cls;
    reg_class_e rd_cls;
    exec_unit_e unit;
    logic       serialise;
    logic       illegal;
  } iw_usage_s;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FLOAD  = 7'b0000111;
  localparam logic [6:0] OP_FSTORE = 7'b0100111;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;
  localparam logic [6:0] OP_F_OPS  = 7'b1010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_ECSR   = 7'b1110011;

  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam logic [6:0] F7_FCVTW   = 7'b1100000;
  localparam logic [6:0] F7_FMV_CLS = 7'b1110000;
  localparam logic [6:0] F7_FCMP    = 7'b1010000;
  localparam logic [6:0] F7_FCVTS   = 7'b1101000;
  localparam logic [6:0] F7_FMVWX   = 7'b1111000;
  localparam logic [6:0] F7_FSQRT   = 7'b0101100;

  // Integer x0 is hard-wired zero, so it can never be the subject of a hazard.
  function automatic logic reg_busy(reg_class_e cls, logic [4:0] idx,
                                    logic [31:0] int_pend, logic [31:0] fp_pend);
    logic busy;
    busy = 1'b0;
    case (cls)
      CLS_INT: busy = (idx != 5'd0) && int_pend[idx];
      CLS_FP:  busy = fp_pend[idx];
      default: busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/issue_decoder.sv
// Combinational decode of one instruction word into its register usage,
// target execution unit and serialisation/illegal flags.
module issue_decoder
  import issue_scoreboard_pkg::*;
(
  input  instruction_t iw,
  output iw_usage_s    usage
);

  logic unused_fields;
  assign unused_fields = ^{iw.rd, iw.rs1, iw.rs2, iw.funct3};

  always_comb begin
    usage           = '0;
    usage.rs1_cls   = CLS_NONE;
    usage.rs2_cls   = CLS_NONE;
    usage.rs3_cls   = CLS_NONE;
    usage.rd_cls    = CLS_NONE;
    usage.unit      = UNIT_ALU;
    usage.serialise = 1'b0;
    usage.illegal   = 1'b0;
    case (iw.opcode)
      OP_LUI, OP_AUIPC, OP_JAL: usage.rd_cls = CLS_INT;
      OP_JALR, OP_ALU_I: begin
        usage.rs1_cls = CLS_INT;
        usage.rd_cls  = CLS_INT;
      end
      OP_LOAD: begin
        usage.rs1_cls = CLS_INT;
        usage.rd_cls  = CLS_INT;
        usage.unit    = UNIT_LSU;
      end
      OP_BRANCH: begin
        usage.rs1_cls = CLS_INT;
        usage.rs2_cls = CLS_INT;
      end
      OP_STORE: begin
        usage.rs1_cls = CLS_INT;
        usage.rs2_cls = CLS_INT;
        usage.unit    = UNIT_LSU;
      end
      OP_REG: begin
        usage.rs1_cls = CLS_INT;
        usage.rs2_cls = CLS_INT;
        usage.rd_cls  = CLS_INT;
        if (iw.funct7 == F7_MULDIV) usage.unit = UNIT_MULDIV;
      end
      OP_FLOAD: begin
        usage.rs1_cls = CLS_INT;
        usage.rd_cls  = CLS_FP;
        usage.unit    = UNIT_LSU;
      end
      OP_FSTORE: begin
        usage.rs1_cls = CLS_INT;
        usage.rs2_cls = CLS_FP;
        usage.unit    = UNIT_LSU;
      end
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
        usage.rs1_cls = CLS_FP;
        usage.rs2_cls = CLS_FP;
        usage.rs3_cls = CLS_FP;
        usage.rd_cls  = CLS_FP;
        usage.unit    = UNIT_FPU;
      end
      // F_OPS register classes depend on funct7: conversions and moves cross files.
      OP_F_OPS: begin
        usage.unit = UNIT_FPU;
        case (iw.funct7)
          F7_FCVTW, F7_FMV_CLS: begin
            usage.rs1_cls = CLS_FP;
            usage.rd_cls  = CLS_INT;
          end
          F7_FCMP: begin
            usage.rs1_cls = CLS_FP;
            usage.rs2_cls = CLS_FP;
            usage.rd_cls  = CLS_INT;
          end
          F7_FCVTS, F7_FMVWX: begin
            usage.rs1_cls = CLS_INT;
            usage.rd_cls  = CLS_FP;
          end
          F7_FSQRT: begin
            usage.rs1_cls = CLS_FP;
            usage.rd_cls  = CLS_FP;
          end
          default: begin
            usage.rs1_cls = CLS_FP;
            usage.rs2_cls = CLS_FP;
            usage.rd_cls  = CLS_FP;
          end
        endcase
      end
      OP_FENCE: usage.serialise = 1'b1;
      OP_ECSR: begin
        usage.rs1_cls   = CLS_INT;
        usage.rd_cls    = CLS_INT;
        usage.serialise = 1'b1;
      end
      default: usage.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Single-entry issue stage: holds one decoded instruction, blocks it on RAW/WAW
// hazards against the integer/FP pending scoreboards, and hands it to its unit.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  instruction_t iw_i,
  input  logic         iw_valid_i,
  output logic         iw_ready_o,
  output logic         issue_valid_o,
  output exec_unit_e   issue_unit_o,
  output logic [31:0]  issue_iw_o,
  input  logic [3:0]   unit_ready_i,
  input  logic         int_wb_valid_i,
  input  logic [4:0]   int_wb_rd_i,
  input  logic         fp_wb_valid_i,
  input  logic [4:0]   fp_wb_rd_i,
  output logic         illegal_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e       state_q, state_d;
  instruction_t held_iw_q;
  iw_usage_s    held_use_q;
  iw_usage_s    in_use;
  logic [31:0]  int_pend_q, fp_pend_q;
  logic [31:0]  int_clr, fp_clr, int_set, fp_set;
  logic [31:0]  int_chk, fp_chk;
  logic         illegal_q;
  logic         held, hazard, sb_idle, fire, accept, accept_legal;

  issue_decoder u_decoder (
    .iw    (iw_i),
    .usage (in_use)
  );

  assign int_clr = int_wb_valid_i ? (32'd1 << int_wb_rd_i) : 32'd0;
  assign fp_clr  = fp_wb_valid_i  ? (32'd1 << fp_wb_rd_i)  : 32'd0;

  // With bypass, a writeback landing this cycle already counts as not pending.
  assign int_chk = WB_BYPASS ? (int_pend_q & ~int_clr) : int_pend_q;
  assign fp_chk  = WB_BYPASS ? (fp_pend_q & ~fp_clr)   : fp_pend_q;

  assign hazard = reg_busy(held_use_q.rs1_cls, held_iw_q.rs1, int_chk, fp_chk)
                | reg_busy(held_use_q.rs2_cls, held_iw_q.rs2, int_chk, fp_chk)
                | reg_busy(held_use_q.rs3_cls, held_iw_q.funct7[6:2], int_chk, fp_chk)
                | reg_busy(held_use_q.rd_cls, held_iw_q.rd, int_chk, fp_chk);

  assign sb_idle       = (int_chk == 32'd0) && (fp_chk == 32'd0);
  assign held          = (state_q != ST_EMPTY);
  assign issue_valid_o = held && !hazard && (!held_use_q.serialise || sb_idle);
  assign issue_unit_o  = held_use_q.unit;
  assign issue_iw_o    = held_iw_q;
  assign fire          = issue_valid_o && unit_ready_i[held_use_q.unit];
  assign iw_ready_o    = !flush_i && (!held || fire);
  assign accept        = iw_valid_i && iw_ready_o;
  assign accept_legal  = accept && !in_use.illegal;
  assign illegal_o     = illegal_q;

  assign int_set = (fire && held_use_q.rd_cls == CLS_INT && held_iw_q.rd != 5'd0)
                 ? (32'd1 << held_iw_q.rd) : 32'd0;
  assign fp_set  = (fire && held_use_q.rd_cls == CLS_FP)
                 ? (32'd1 << held_iw_q.rd) : 32'd0;

  // DRAIN marks a serialising instruction still waiting for the scoreboards to empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept_legal) state_d = ST_HELD;
      ST_HELD, ST_DRAIN: begin
        if (fire)
          state_d = accept_legal ? ST_HELD : ST_EMPTY;
        else if (held_use_q.serialise && !sb_idle)
          state_d = ST_DRAIN;
        else
          state_d = ST_HELD;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_EMPTY;
      held_iw_q  <= '0;
      held_use_q <= '0;
      int_pend_q <= '0;
      fp_pend_q  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= accept && in_use.illegal;
      if (accept_legal) begin
        held_iw_q  <= iw_i;
        held_use_q <= in_use;
      end
      // Set is applied after clear so an issue wins over a same-cycle writeback.
      if (flush_i) begin
        int_pend_q <= '0;
        fp_pend_q  <= '0;
      end else begin
        int_pend_q <= (int_pend_q & ~int_clr) | int_set;
        fp_pend_q  <= (fp_pend_q & ~fp_clr) | fp_set;
      end
    end
  end

endmodule
